carfield_domain_ctrl: RTL
=========================

CARFIELD_DOMAIN_CTRL -- requirements
Module: carfield_domain_ctrl

Interface
REQ-001 SHALL have parameter NumDomains, default 6, giving the number of gateable domains; bit index follows the carfield domain index (0 = periph).
REQ-002 SHALL have parameter ResetCyclesDefault, default 16, giving the reset value of RST_CYCLES.
REQ-003 SHALL have parameter GateCycles, default 2, giving the length of the GATE and SETTLE phases in cycles.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is in this domain.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port reg_req_i, input, carfield_a32_d32_reg_req_t: regbus request (addr[31:0], write, wdata[31:0], wstrb[3:0], valid).
REQ-007 SHALL have port reg_rsp_o, output, carfield_a32_d32_reg_rsp_t: regbus response (rdata[31:0], error, ready).
REQ-008 SHALL have port domain_clk_en_o, output, NumDomains bits: per-domain clock-gate enable, registered.
REQ-009 SHALL have port domain_rst_no, output, NumDomains bits: per-domain active-low reset, registered.

Function
REQ-010 SHALL decode addr[4:0] into these registers; all other offsets and non-word-aligned addresses are unmapped.
- 0x00 CLK_EN: RW, bits [NumDomains-1:0].
- 0x04 RST_REQ: write-1-to-start; reads return 0.
- 0x08 STATUS: RO; [5:0] busy, [13:8] held.
- 0x0C RST_CYCLES: RW, bits [7:0].
REQ-011 SHALL assert reg_rsp_o.ready in the same cycle as valid, with rdata combinational; a write commits at that clock edge, honouring wstrb per byte.
REQ-012 SHALL set reg_rsp_o.error for an unmapped offset and for a write to STATUS; no state changes in either case.
REQ-013 SHALL run one FSM per domain with states HELD, IDLE, GATE, RESET, SETTLE.
REQ-014 SHALL move HELD or IDLE to GATE on the edge that commits RST_REQ bit i = 1; a request in any other state is ignored, with no restart or queueing.
REQ-015 SHALL hold GATE for GateCycles cycles with clk_en = 0 and rst_n = 1, then enter RESET.
REQ-016 SHALL, on entry to RESET, load the counter with max(RST_CYCLES, 1); rst_n = 0 and clk_en = 0 for that many cycles, then enter SETTLE.
REQ-017 SHALL hold SETTLE for GateCycles cycles with rst_n = 1 and clk_en = 0, then enter IDLE.
REQ-018 SHALL drive clk_en = CLK_EN[i] and rst_n = 1 in IDLE, and clk_en = 0 and rst_n = 0 in HELD.
REQ-019 SHALL apply a CLK_EN write during a sequence to the register immediately, with the output following only on IDLE entry.
REQ-020 SHALL apply a RST_CYCLES write during RESET to the next sequence only.
REQ-021 SHALL, for an RST_REQ commit at edge T, give: GATE from T+1; rst_n low from T+1+GateCycles for N cycles; IDLE with clock restored at T+1+2*GateCycles+N.
REQ-022 SHALL set STATUS busy[i] = 1 in GATE, RESET or SETTLE, and held[i] = 1 in HELD; STATUS is read from the state register without added latency.
REQ-023 SHALL start simultaneous requests for several domains in parallel, with independent counters.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously reset to:
- CLK_EN = 1 (bit 0 only); RST_CYCLES = ResetCyclesDefault.
- Domain 0 in IDLE; all other domains in HELD.
- domain_clk_en_o = 1; domain_rst_no = 1; reg_rsp_o.error = 0.
REQ-025 SHALL, on rst_ni assertion mid-sequence, abort the sequence and return to the REQ-024 state.

Configuration
REQ-026 SHALL, when CARFIELD_DOMAIN_LOCK_EN is defined, add a LOCK register at 0x10, with bits [NumDomains-1:0] settable only and cleared only by rst_ni.
REQ-027 SHALL, with CARFIELD_DOMAIN_LOCK_EN defined, respond error = 1 and make no change when a CLK_EN or RST_REQ write attempts to modify or request a locked domain.
REQ-028 SHALL, without CARFIELD_DOMAIN_LOCK_EN, treat offset 0x10 as unmapped (error = 1) and provide no lock logic.

Verification
REQ-029 SHALL cover reset release: STATUS reads 0x3E00; clk_en = 0x01; rst_n = 0x01; read of 0x14 returns error = 1.
REQ-030 SHALL cover RST_CYCLES = 4, then RST_REQ = 0x08 at T: GATE at T+1..T+2, rst_n[3] low at T+3..T+6, clk_en[3] = CLK_EN[3] at T+9.
REQ-031 SHALL cover RST_CYCLES = 0 with a request on domain 1: rst_n[1] low for exactly 1 cycle.
REQ-032 SHALL cover a second RST_REQ for domain 2 during RESET: the sequence length is unchanged and exactly one rst_n pulse occurs.
REQ-033 SHALL cover an RST_REQ = 0x06 commit plus a CLK_EN = 0x00 write during RESET: both domains release together, and clk_en[2:1] stays 0 in IDLE.
REQ-034 SHALL cover, with CARFIELD_DOMAIN_LOCK_EN defined, LOCK = 0x10 then RST_REQ = 0x10: error = 1, domain 4 stays HELD, and a LOCK write of 0 leaves LOCK = 0x10.

Source files
------------

// File: rtl/carfield_domain_ctrl.sv
// carfield_domain_ctrl: per-domain clock-gate and reset sequencer behind a regbus slave.
// Each domain runs HELD/IDLE -> GATE -> RESET -> SETTLE -> IDLE when RST_REQ is written.
// Optional feature: define CARFIELD_DOMAIN_LOCK_EN to add the set-only LOCK register at 0x10.
// The regbus structs travel as packed vectors with the carfield_a32_d32 layout:
//   reg_req_i = {addr[31:0], write, wdata[31:0], wstrb[3:0], valid}   (70 bits)
//   reg_rsp_o = {rdata[31:0], error, ready}                           (34 bits)
// Domain-indexed register fields live in byte 0, so NumDomains is at most 8.
module carfield_domain_ctrl #(
  parameter int unsigned NumDomains         = 6,
  parameter int unsigned ResetCyclesDefault = 16,
  parameter int unsigned GateCycles         = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [69:0]           reg_req_i,
  output logic [33:0]           reg_rsp_o,
  output logic [NumDomains-1:0] domain_clk_en_o,
  output logic [NumDomains-1:0] domain_rst_no
);

  typedef enum logic [2:0] {
    ST_HELD,
    ST_IDLE,
    ST_GATE,
    ST_RESET,
    ST_SETTLE
  } dom_state_e;

  localparam logic [7:0]            GateLoad    = 8'(GateCycles - 1);
  localparam logic [7:0]            RstCycRst   = 8'(ResetCyclesDefault);
  localparam logic [NumDomains-1:0] Dom0Only    = NumDomains'(1);

  // Counter preload for RESET: max(cycles, 1) cycles, counted down to zero.
  function automatic logic [7:0] reset_load(input logic [7:0] cycles);
    return (cycles == 8'd0) ? 8'd0 : cycles - 8'd1;
  endfunction

  // Request fields
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_write;
  logic        req_valid;

  assign {req_addr, req_write, req_wdata, req_wstrb, req_valid} = reg_req_i;

  // Only addr[4:0] is decoded and only byte 0 carries register bits.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_addr[31:5], req_wdata[31:8], req_wstrb[3:1]};

  // Register state
  logic [NumDomains-1:0] clk_en_q, clk_en_d;
  logic [7:0]            rst_cycles_q, rst_cycles_d;
  logic [NumDomains-1:0] start_req;

  // Domain FSM state
  dom_state_e state_q [NumDomains];
  dom_state_e state_d [NumDomains];
  logic [7:0] cnt_q   [NumDomains];
  logic [7:0] cnt_d   [NumDomains];

  logic [NumDomains-1:0] dom_clk_q, dom_clk_d;
  logic [NumDomains-1:0] dom_rst_q, dom_rst_d;

  // Address decode
  logic aligned, sel_clk, sel_req, sel_sts, sel_cyc, sel_lock, mapped;
  logic lock_err, err, wr_ok;

  assign aligned = (req_addr[1:0] == 2'b00);
  assign sel_clk = aligned && (req_addr[4:2] == 3'd0);
  assign sel_req = aligned && (req_addr[4:2] == 3'd1);
  assign sel_sts = aligned && (req_addr[4:2] == 3'd2);
  assign sel_cyc = aligned && (req_addr[4:2] == 3'd3);

  // Byte-0 write data merged with wstrb[0]
  logic [NumDomains-1:0] wr_clk_en;
  logic [NumDomains-1:0] wr_set_bits;
  logic [7:0]            wr_cycles;

  assign wr_clk_en   = req_wstrb[0] ? req_wdata[NumDomains-1:0] : clk_en_q;
  assign wr_set_bits = req_wstrb[0] ? req_wdata[NumDomains-1:0] : '0;
  assign wr_cycles   = req_wstrb[0] ? req_wdata[7:0] : rst_cycles_q;

`ifdef CARFIELD_DOMAIN_LOCK_EN
  logic [NumDomains-1:0] lock_q, lock_d;

  assign sel_lock = aligned && (req_addr[4:2] == 3'd4);
  // A write may not flip a locked CLK_EN bit nor request a locked domain.
  assign lock_err = req_write &&
                    ((sel_clk && |((wr_clk_en ^ clk_en_q) & lock_q)) ||
                     (sel_req && |(wr_set_bits & lock_q)));

  // LOCK bits can only be set by software
  always_comb begin
    lock_d = lock_q;
    if (wr_ok && sel_lock) lock_d = lock_q | wr_set_bits;
  end

  // LOCK register, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_q <= '0;
    else         lock_q <= lock_d;
  end
`else
  assign sel_lock = 1'b0;
  assign lock_err = 1'b0;
`endif

  assign mapped = sel_clk || sel_req || sel_sts || sel_cyc || sel_lock;
  assign err    = req_valid && (!mapped || (req_write && sel_sts) || lock_err);
  assign wr_ok  = req_valid && req_write && !err;

  // Register writes and the per-domain start pulses they generate
  always_comb begin
    clk_en_d     = clk_en_q;
    rst_cycles_d = rst_cycles_q;
    start_req    = '0;
    if (wr_ok) begin
      if (sel_clk) clk_en_d     = wr_clk_en;
      if (sel_cyc) rst_cycles_d = wr_cycles;
      if (sel_req) start_req    = wr_set_bits;
    end
  end

  // Configuration registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_en_q     <= Dom0Only;
      rst_cycles_q <= RstCycRst;
    end else begin
      clk_en_q     <= clk_en_d;
      rst_cycles_q <= rst_cycles_d;
    end
  end

  // STATUS and read data, straight from the state register
  logic [NumDomains-1:0] busy_vec, held_vec;
  logic [31:0]           status, rdata;

  always_comb begin
    busy_vec = '0;
    held_vec = '0;
    for (int i = 0; i < NumDomains; i++) begin
      busy_vec[i] = (state_q[i] == ST_GATE) || (state_q[i] == ST_RESET) ||
                    (state_q[i] == ST_SETTLE);
      held_vec[i] = (state_q[i] == ST_HELD);
    end
    status = 32'(busy_vec) | (32'(held_vec) << 8);
  end

  // Combinational read mux; RST_REQ and unmapped offsets read as zero
  always_comb begin
    rdata = '0;
    if (sel_clk)      rdata[NumDomains-1:0] = clk_en_q;
    else if (sel_sts) rdata                 = status;
    else if (sel_cyc) rdata[7:0]            = rst_cycles_q;
`ifdef CARFIELD_DOMAIN_LOCK_EN
    else if (sel_lock) rdata[NumDomains-1:0] = lock_q;
`endif
  end

  assign reg_rsp_o = {rdata, err, req_valid};

  // Domain state and phase counter registers; domain 0 leaves reset running
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumDomains; i++) begin
        state_q[i] <= (i == 0) ? ST_IDLE : ST_HELD;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NumDomains; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state: requests only start from HELD or IDLE, each phase counts down to zero
  always_comb begin
    for (int i = 0; i < NumDomains; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_HELD, ST_IDLE: begin
          if (start_req[i]) begin
            state_d[i] = ST_GATE;
            cnt_d[i]   = GateLoad;
          end
        end
        ST_GATE: begin
          if (cnt_q[i] == 8'd0) begin
            state_d[i] = ST_RESET;
            cnt_d[i]   = reset_load(rst_cycles_q);
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        ST_RESET: begin
          if (cnt_q[i] == 8'd0) begin
            state_d[i] = ST_SETTLE;
            cnt_d[i]   = GateLoad;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q[i] == 8'd0) state_d[i] = ST_IDLE;
          else                  cnt_d[i]   = cnt_q[i] - 8'd1;
        end
        default: state_d[i] = ST_HELD;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs align with it
  always_comb begin
    dom_clk_d = '0;
    dom_rst_d = '0;
    for (int i = 0; i < NumDomains; i++) begin
      unique case (state_d[i])
        ST_IDLE: begin
          dom_clk_d[i] = clk_en_d[i];
          dom_rst_d[i] = 1'b1;
        end
        ST_GATE, ST_SETTLE: dom_rst_d[i] = 1'b1;
        default: begin
          dom_clk_d[i] = 1'b0;
          dom_rst_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Registered clock-enable and reset outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dom_clk_q <= Dom0Only;
      dom_rst_q <= Dom0Only;
    end else begin
      dom_clk_q <= dom_clk_d;
      dom_rst_q <= dom_rst_d;
    end
  end

  assign domain_clk_en_o = dom_clk_q;
  assign domain_rst_no   = dom_rst_q;

endmodule
